// File: rtl/pon_pkg.sv
// Shared constants and state types for the power-on banner / echo / command block.
package pon_pkg;

    localparam int unsigned DefaultClkHz = 25_000_000;
    localparam int unsigned DefaultBaud  = 115_200;

    localparam int unsigned BannerLen = 5;
    localparam logic [7:0]  BannerP   = 8'h50;
    localparam logic [7:0]  BannerO   = 8'h4F;
    localparam logic [7:0]  BannerN   = 8'h4E;
    localparam logic [7:0]  BannerCr  = 8'h0D;
    localparam logic [7:0]  BannerLf  = 8'h0A;

    localparam logic [7:0] CmdLedUpper  = 8'h4C;
    localparam logic [7:0] CmdLedLower  = 8'h6C;
    localparam logic [7:0] CmdBeepUpper = 8'h42;
    localparam logic [7:0] CmdBeepLower = 8'h62;

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;
    typedef enum logic {TxIdle, TxSend} tx_state_e;

    function automatic logic [7:0] banner_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return BannerP;
            3'd1:    return BannerO;
            3'd2:    return BannerN;
            3'd3:    return BannerCr;
            default: return BannerLf;
        endcase
    endfunction

endpackage

// File: rtl/pon_uart.sv
// 8N1 UART: 2-flop RX synchronizer, mid-bit sampling receiver and a transmitter
// that accepts the next byte in the last stop-bit cycle so frames run back-to-back.
module pon_uart
    import pon_pkg::*;
#(
    parameter int unsigned DIV = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    output logic       tx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready
);

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] BitLast  = CW'(DIV - 1);
    localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);

    logic [1:0]    rx_sync_q;
    logic          rx_s, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bits_q, rx_bits_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    assign rx_s     = rx_sync_q[1];
    assign rx_data  = rx_shift_q;
    assign rx_valid = rx_valid_q;
    assign tx_line  = tx_line_q;
    assign tx_ready = (tx_state_q == TxIdle) || (tx_bits_q == 4'd9 && tx_cnt_q == BitLast);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s) rx_state_d = RxStart;
            end
            RxStart: if (rx_cnt_q == HalfLast) begin
                rx_cnt_d   = '0;
                rx_bits_d  = '0;
                rx_state_d = rx_s ? RxIdle : RxData;
            end
            RxData: if (rx_cnt_q == BitLast) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                rx_bits_d  = rx_bits_q + 1'b1;
                if (rx_bits_q == 3'd7) rx_state_d = RxStop;
            end
            RxStop: if (rx_cnt_q == BitLast) begin
                rx_valid_d = rx_s;
                // A low stop bit is a framing error: wait for the line to recover.
                rx_state_d = rx_s ? RxIdle : RxWaitHigh;
            end
            RxWaitHigh: if (rx_s) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        if (tx_start && tx_ready) begin
            tx_state_d = TxSend;
            tx_cnt_d   = '0;
            tx_bits_d  = '0;
            tx_shift_d = {1'b1, tx_data};
            tx_line_d  = 1'b0;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_d  = '0;
                    tx_line_d = 1'b1;
                end
                TxSend: if (tx_cnt_q == BitLast) begin
                    tx_cnt_d  = '0;
                    tx_bits_d = tx_bits_q + 1'b1;
                    if (tx_bits_q == 4'd9) begin
                        tx_state_d = TxIdle;
                    end else begin
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    end
                end
                default: tx_state_d = TxIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_shift_q <= '1;
            tx_line_q  <= 1'b1;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx_line};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

endmodule

// File: rtl/project_pon_vcentury.sv
// Power-on banner "PON\r\n", LED toggle and buzzer beep commands over UART.
// Define PON_ECHO_EN to echo each received byte through a one-byte holding register.
module project_pon_vcentury
    import pon_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DefaultClkHz,
    parameter int unsigned BAUD    = DefaultBaud,
    parameter int unsigned BEEP_HZ = 1000,
    parameter int unsigned BEEP_MS = 100
) (
    input  logic CLK,
    input  logic IN_PB_RESET,
    input  logic IN_SERIAL_RX,
    output logic OUT_SERIAL_TX,
    output logic OUT_LED,
    output logic OUT_BUZZER
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = CLK_HZ / (2 * BEEP_HZ);
    localparam int unsigned DUR  = 32'(64'(CLK_HZ) * 64'(BEEP_MS) / 64'd1000);

    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, tx_start, tx_ready;
    logic [2:0]  banner_idx_q, banner_idx_d;
    logic        banner_pending, is_led, is_beep;
    logic        led_q, beep_on_q, beep_on_d, buzz_q, buzz_d;
    logic [31:0] dur_q, dur_d, tone_q, tone_d;

    pon_uart #(
        .DIV(DIV)
    ) u_uart (
        .clk     (CLK),
        .rst_n   (IN_PB_RESET),
        .rx_line (IN_SERIAL_RX),
        .tx_line (OUT_SERIAL_TX),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_ready(tx_ready)
    );

    assign banner_pending = (banner_idx_q != 3'(BannerLen));
    assign banner_idx_d   = (tx_start && banner_pending) ? banner_idx_q + 1'b1 : banner_idx_q;

`ifdef PON_ECHO_EN
    logic       hold_full_q, hold_full_d, hold_take;
    logic [7:0] hold_data_q, hold_data_d;

    assign tx_start = tx_ready && (banner_pending || hold_full_q);
    assign tx_data  = banner_pending ? banner_byte(banner_idx_q) : hold_data_q;

    always_comb begin
        hold_take   = tx_start && !banner_pending;
        hold_full_d = hold_full_q && !hold_take;
        hold_data_d = hold_data_q;
        // A byte arriving while the slot is occupied loses its echo.
        if (rx_valid && (!hold_full_q || hold_take)) begin
            hold_full_d = 1'b1;
            hold_data_d = rx_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end
`else
    assign tx_start = tx_ready && banner_pending;
    assign tx_data  = banner_byte(banner_idx_q);
`endif

    assign is_led  = rx_valid && (rx_data == CmdLedUpper || rx_data == CmdLedLower);
    assign is_beep = rx_valid && (rx_data == CmdBeepUpper || rx_data == CmdBeepLower);

    always_comb begin
        beep_on_d = beep_on_q;
        dur_d     = dur_q;
        tone_d    = tone_q;
        buzz_d    = buzz_q;
        if (beep_on_q) begin
            dur_d  = dur_q + 32'd1;
            tone_d = tone_q + 32'd1;
            if (tone_q == HALF - 1) begin
                tone_d = '0;
                buzz_d = !buzz_q;
            end
            if (dur_q == DUR - 1) begin
                beep_on_d = 1'b0;
                buzz_d    = 1'b0;
            end
        end
        // Retrigger only restarts the duration; the tone phase keeps running.
        if (is_beep) begin
            beep_on_d = 1'b1;
            dur_d     = '0;
            if (!beep_on_q) begin
                tone_d = '0;
                buzz_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) begin
            banner_idx_q <= '0;
            led_q        <= 1'b0;
            beep_on_q    <= 1'b0;
            dur_q        <= '0;
            tone_q       <= '0;
            buzz_q       <= 1'b0;
        end else begin
            banner_idx_q <= banner_idx_d;
            led_q        <= led_q ^ is_led;
            beep_on_q    <= beep_on_d;
            dur_q        <= dur_d;
            tone_q       <= tone_d;
            buzz_q       <= buzz_d;
        end
    end

    assign OUT_LED    = led_q;
    assign OUT_BUZZER = buzz_q;

endmodule

// File: tb/tb_project_pon_vcentury.sv
// Randomized self-checking bench for project_pon_vcentury with scaled-down timing.
module tb_project_pon_vcentury;

    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int unsigned BAUD    = 100_000;
    localparam int unsigned BEEP_HZ = 10_000;
    localparam int unsigned BEEP_MS = 2;
    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned HALF    = CLK_HZ / (2 * BEEP_HZ);
    localparam int unsigned DUR     = CLK_HZ * BEEP_MS / 1000;
    localparam int          TraceLen = 3600;
`ifdef PON_ECHO_EN
    localparam bit EchoEn = 1'b1;
`else
    localparam bit EchoEn = 1'b0;
`endif

    logic CLK = 1'b0;
    logic IN_PB_RESET = 1'b0;
    logic IN_SERIAL_RX = 1'b1;
    logic OUT_SERIAL_TX, OUT_LED, OUT_BUZZER;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    logic [7:0]  mon_data[$];
    int unsigned mon_start[$];
    int unsigned mon_stop_err = 0;
    logic        mon_prev = 1'b1;
    logic [7:0]  mon_byte;
    logic        mon_rst_seen, mon_stop;
    int unsigned mon_t0;

    logic [7:0]  exp_q[$];
    logic        exp_led = 1'b0;
    int unsigned last_send_cyc = 0;
    logic        trace [TraceLen];
    int          lat, f_rise, s_rise, t_idx, bad, rel, end_rel, delta, s1;
    logic [7:0]  rb;
    logic        rok, expv;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    project_pon_vcentury #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .BEEP_HZ(BEEP_HZ),
        .BEEP_MS(BEEP_MS)
    ) dut (
        .CLK          (CLK),
        .IN_PB_RESET  (IN_PB_RESET),
        .IN_SERIAL_RX (IN_SERIAL_RX),
        .OUT_SERIAL_TX(OUT_SERIAL_TX),
        .OUT_LED      (OUT_LED),
        .OUT_BUZZER   (OUT_BUZZER)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TX line decoder: mid-bit sampling on falling clock edges; frames overlapping reset dropped.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_prev && !OUT_SERIAL_TX) begin
                mon_t0 = cyc;
                mon_rst_seen = !IN_PB_RESET;
                repeat (DIV / 2 - 1) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge CLK);
                    mon_byte[i] = OUT_SERIAL_TX;
                    mon_rst_seen = mon_rst_seen | !IN_PB_RESET;
                end
                repeat (DIV) @(negedge CLK);
                mon_stop = OUT_SERIAL_TX;
                mon_rst_seen = mon_rst_seen | !IN_PB_RESET;
                if (!mon_rst_seen) begin
                    mon_data.push_back(mon_byte);
                    mon_start.push_back(mon_t0);
                    if (!mon_stop) mon_stop_err++;
                end
            end
            mon_prev = OUT_SERIAL_TX;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge CLK);
        IN_SERIAL_RX = 1'b0;
        last_send_cyc = cyc;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            IN_SERIAL_RX = b[i];
            repeat (DIV) @(negedge CLK);
        end
        IN_SERIAL_RX = stop_bit;
        repeat (DIV) @(negedge CLK);
        IN_SERIAL_RX = 1'b1;
    endtask

    // Reference: good frames echo (when enabled) and L/l flips the LED; bad frames vanish.
    task automatic model_rx(input logic [7:0] b, input logic ok);
        if (ok) begin
            if (EchoEn) exp_q.push_back(b);
            if (b == 8'h4C || b == 8'h6C) exp_led = !exp_led;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ok);
        send_rx(b, ok);
        model_rx(b, ok);
        repeat (3 * DIV) @(negedge CLK);
    endtask

    task automatic push_banner();
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h4E);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic drain_compare(input string tag);
        int unsigned waited = 0;
        while (mon_data.size() < exp_q.size() && waited < 40 * DIV * (exp_q.size() + 1)) begin
            @(negedge CLK);
            waited++;
        end
        repeat (12 * DIV) @(negedge CLK);
        check_eq({tag, "_count"}, mon_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_data.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), mon_data[i], exp_q[i]);
        mon_data.delete();
        mon_start.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (10) @(negedge CLK);
        check_eq("rst_tx", OUT_SERIAL_TX, 1);
        check_eq("rst_led", OUT_LED, 0);
        check_eq("rst_buzz", OUT_BUZZER, 0);

        IN_PB_RESET = 1'b1;
        push_banner();
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (OUT_SERIAL_TX && lat < 8);
        check_eq("banner_latency_ok", (lat >= 1 && lat <= 2), 1);
        for (int w = 0; w < 80 * DIV && mon_data.size() < 5; w++) @(negedge CLK);
        for (int i = 1; i < 5 && i < mon_start.size(); i++)
            check_eq($sformatf("banner_gap%0d", i), mon_start[i] - mon_start[i-1], 10 * DIV);
        drain_compare("banner");
        check_eq("banner_led", OUT_LED, 0);
        check_eq("banner_buzz", OUT_BUZZER, 0);

        send_byte(8'h78, 1'b1);
        drain_compare("echo_x");
        check_eq("x_led", OUT_LED, exp_led);
        check_eq("x_buzz", OUT_BUZZER, 0);

        send_byte(8'h4C, 1'b1);
        check_eq("led_on", OUT_LED, exp_led);
        send_byte(8'h6C, 1'b1);
        check_eq("led_off", OUT_LED, exp_led);
        drain_compare("echo_ll");

        send_byte(8'h41, 1'b0);
        check_eq("ferr_led", OUT_LED, exp_led);
        send_byte(8'h4C, 1'b1);
        check_eq("after_ferr_led", OUT_LED, exp_led);
        drain_compare("ferr");

        // Beep with a retrigger partway through; buzzer trace checked against an ideal waveform.
        fork
            begin
                send_rx(8'h62, 1'b1);
                s1 = last_send_cyc;
                while (cyc < s1 + 1073) @(negedge CLK);
                send_rx(8'h62, 1'b1);
                delta = last_send_cyc - s1;
            end
            begin
                for (int i = 0; i < TraceLen; i++) begin
                    @(negedge CLK);
                    trace[i] = OUT_BUZZER;
                end
            end
        join
        model_rx(8'h62, 1'b1);
        model_rx(8'h62, 1'b1);
        f_rise = -1;
        s_rise = -1;
        for (int i = 1; i < TraceLen; i++) begin
            if (trace[i] && !trace[i-1]) begin
                if (f_rise < 0) f_rise = i;
                else if (s_rise < 0) s_rise = i;
            end
        end
        check_eq("beep_started", (f_rise >= int'(HALF)), 1);
        check_eq("beep_period", s_rise - f_rise, 2 * HALF);
        bad = 0;
        if (f_rise >= int'(HALF)) begin
            t_idx = f_rise - int'(HALF);
            end_rel = delta + int'(DUR);
            for (int i = t_idx; i < TraceLen; i++) begin
                rel = i - t_idx;
                expv = (rel < end_rel) && (((rel / int'(HALF)) % 2) == 1);
                if (trace[i] !== expv) bad++;
            end
        end
        check_eq("beep_wave_errors", bad, 0);
        check_eq("beep_end_low", trace[TraceLen-1], 0);
        check_eq("beep_led", OUT_LED, exp_led);
        drain_compare("beep");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: rb = 8'h4C;
                1: rb = 8'h6C;
                2: rb = 8'h42;
                3: rb = 8'h62;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            rok = ($urandom_range(0, 7) != 0);
            send_byte(rb, rok);
            check_eq($sformatf("rand_led%0d", n), OUT_LED, exp_led);
        end
        drain_compare("rand");
        repeat (DUR + 100) @(negedge CLK);
        check_eq("rand_buzz_silent", OUT_BUZZER, 0);

        // Reset during banner byte 3 after an 'L' landed mid-banner.
        @(negedge CLK);
        IN_PB_RESET = 1'b0;
        repeat (5) @(negedge CLK);
        mon_data.delete();
        mon_start.delete();
        exp_q.delete();
        exp_led = 1'b0;
        check_eq("rst2_led", OUT_LED, 0);
        IN_PB_RESET = 1'b1;
        send_rx(8'h4C, 1'b1);
        repeat (2) @(negedge CLK);
        check_eq("mid_banner_led", OUT_LED, 1);
        for (int w = 0; w < 40 * DIV && mon_data.size() < 2; w++) @(negedge CLK);
        lat = 0;
        while (OUT_SERIAL_TX && lat < 20 * DIV) begin
            @(negedge CLK);
            lat++;
        end
        check_eq("byte3_started", OUT_SERIAL_TX, 0);
        IN_PB_RESET = 1'b0;
        @(negedge CLK);
        check_eq("abort_tx", OUT_SERIAL_TX, 1);
        check_eq("abort_led", OUT_LED, 0);
        check_eq("abort_buzz", OUT_BUZZER, 0);
        repeat (12 * DIV) @(negedge CLK);
        mon_data.delete();
        mon_start.delete();
        exp_q.delete();
        IN_PB_RESET = 1'b1;
        push_banner();
        drain_compare("rebanner");
        check_eq("rebanner_led", OUT_LED, 0);
        check_eq("tx_stop_bits", mon_stop_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
